// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU memory-stage and block-memory signals of the data cache
interface data_cache_if;
  // CPU memory-stage side
  logic [3:0]   memReadEn;
  logic [2:0]   memWriteEn;
  logic [31:0]  DATA_CACHE_ADDR;
  logic [31:0]  DATA_CACHE_DATA;
  logic [31:0]  DATA_CACHE_READ_DATA;
  logic         DATA_CACHE_BUSY_WAIT;
  // block memory side
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  // statistics
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  // the cache itself
  modport slave (
    input  memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
    input  mem_readdata, mem_busywait,
    output DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
    output mem_read, mem_write, mem_address, mem_writedata,
    output hit_count, miss_count
  );

  // the environment: CPU pipeline plus block memory
  modport master (
    output memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
    output mem_readdata, mem_busywait,
    input  DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
    input  mem_read, mem_write, mem_address, mem_writedata,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache (optional stats: DATA_CACHE_STATS_EN)
module data_cache #(
  parameter int NUM_SETS = 8
) (
  input logic        CLK,
  input logic        RESET,
  data_cache_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [NUM_SETS];
  logic [127:0]       data_q [NUM_SETS];
  logic [127:0]       fill_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [1:0]         word_sel;
  logic               rd_req, wr_req, req, hit, idle;
  logic [127:0]       line;
  logic [31:0]        cur_word, ld_word, st_word;
  logic [127:0]       st_line;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  assign idx      = bus.DATA_CACHE_ADDR[4+IDX_W-1:4];
  assign addr_tag = bus.DATA_CACHE_ADDR[31:4+IDX_W];
  assign word_sel = bus.DATA_CACHE_ADDR[3:2];
  assign rd_req   = bus.memReadEn[3];
  assign wr_req   = bus.memWriteEn[2];
  assign req      = rd_req | wr_req;
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign idle     = (state_q == IDLE);
  assign line     = data_q[idx];
  assign cur_word = line[{word_sel, 5'b00000} +: 32];
  assign ld_byte  = cur_word[{bus.DATA_CACHE_ADDR[1:0], 3'b000} +: 8];
  assign ld_half  = cur_word[{bus.DATA_CACHE_ADDR[1], 4'b0000} +: 16];

  // load lane selection and sign/zero extension; zero whenever no load is requested
  always_comb begin
    ld_word = cur_word;
    case (bus.memReadEn[2:0])
      3'b000:  ld_word = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_word = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_word = {24'h0, ld_byte};
      3'b101:  ld_word = {16'h0, ld_half};
      default: ld_word = cur_word;
    endcase
    bus.DATA_CACHE_READ_DATA = (rd_req && !RESET) ? ld_word : 32'h0;
  end

  // store merge: only the selected byte lanes of the addressed word change
  always_comb begin
    st_word = cur_word;
    case (bus.memWriteEn[1:0])
      2'b00:   st_word[{bus.DATA_CACHE_ADDR[1:0], 3'b000} +: 8]  = bus.DATA_CACHE_DATA[7:0];
      2'b01:   st_word[{bus.DATA_CACHE_ADDR[1], 4'b0000} +: 16] = bus.DATA_CACHE_DATA[15:0];
      default: st_word = bus.DATA_CACHE_DATA;
    endcase
    st_line = line;
    st_line[{word_sel, 5'b00000} +: 32] = st_word;
  end

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: misses evict a dirty line first, then fetch and install
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req && !hit) state_d = dirty_q[idx] ? WRITE_BACK : FETCH;
      WRITE_BACK: if (!bus.mem_busywait) state_d = FETCH;
      FETCH:      if (!bus.mem_busywait) state_d = UPDATE;
      UPDATE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // outputs: memory requests decode from the registered state only
  always_comb begin
    bus.mem_read      = (state_q == FETCH);
    bus.mem_write     = (state_q == WRITE_BACK);
    bus.mem_address   = 28'h0;
    bus.mem_writedata = 128'h0;
    if (state_q == WRITE_BACK) begin
      bus.mem_address   = {tag_q[idx], idx};
      bus.mem_writedata = line;
    end else if (state_q == FETCH) begin
      bus.mem_address   = bus.DATA_CACHE_ADDR[31:4];
    end
    bus.DATA_CACHE_BUSY_WAIT = !RESET && ((idle && req && !hit) || !idle);
  end

  // line status bits; reset invalidates everything, dropping any dirty data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (idle && wr_req && hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // line payload, tags and the fetched-block holding register
  always_ff @(posedge CLK) begin
    if (state_q == FETCH && !bus.mem_busywait) fill_q <= bus.mem_readdata;
    if (state_q == UPDATE) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= addr_tag;
    end else if (idle && wr_req && hit) begin
      data_q[idx] <= st_line;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        cmpl_q;

  // cmpl_q marks the IDLE cycle right after UPDATE, whose hit finishes a miss and is not counted
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_q  <= 32'h0;
      miss_q <= 32'h0;
      cmpl_q <= 1'b0;
    end else begin
      cmpl_q <= (state_q == UPDATE);
      if (idle && req && hit && !cmpl_q) hit_q <= hit_q + 32'h1;
      if (idle && req && !hit)           miss_q <= miss_q + 32'h1;
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = 32'h0;
  assign bus.miss_count = 32'h0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard bench for data_cache with a wait-state block memory model
module tb_data_cache;
  localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101, NR = 4'b0000;
  localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, NW = 3'b000;

  typedef struct {
    logic [3:0]  re;
    logic [2:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          cyc;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if bus();
  data_cache #(.NUM_SETS(8)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  // block memory model
  logic [127:0] mem_blk [logic [27:0]];
  int           mem_wait = 3;
  int           mcnt = 0;
  int           rd_cnt = 0, wr_cnt = 0, both_hi = 0;
  logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) both_hi = both_hi + 1;
    if (!(bus.mem_read || bus.mem_write)) begin
      bus.mem_busywait = 1'b0;
      mcnt = 0;
    end else if (mcnt < mem_wait) begin
      bus.mem_busywait = 1'b1;
      mcnt = mcnt + 1;
    end else begin
      bus.mem_busywait = 1'b0;
      mcnt = 0;
      if (bus.mem_read) begin
        rd_cnt = rd_cnt + 1;
        last_rd_addr = bus.mem_address;
        bus.mem_readdata = mem_blk.exists(bus.mem_address) ? mem_blk[bus.mem_address] : 128'h0;
      end
      if (bus.mem_write) begin
        wr_cnt = wr_cnt + 1;
        last_wr_addr = bus.mem_address;
        last_wr_data = bus.mem_writedata;
        mem_blk[bus.mem_address] = bus.mem_writedata;
      end
    end
  end

  task automatic drive(input logic [3:0] re, input logic [2:0] we, input logic [31:0] a, input logic [31:0] d);
    bus.memReadEn       = re;
    bus.memWriteEn      = we;
    bus.DATA_CACHE_ADDR = a;
    bus.DATA_CACHE_DATA = d;
  endtask

  // entered at posedge+1; returns after the commit edge, again at posedge+1
  task automatic run_req(input logic [3:0] re, input logic [2:0] we, input logic [31:0] a, input logic [31:0] d,
                         output int cycles, output logic [31:0] rdata);
    drive(re, we, a, d);
    #1;
    cycles = 0;
    while (bus.DATA_CACHE_BUSY_WAIT !== 1'b0 && cycles < 100) begin
      @(posedge clk);
      #2;
      cycles++;
    end
    if (bus.DATA_CACHE_BUSY_WAIT !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout addr=%h: busy still %b after %0d cycles, want 0", a, bus.DATA_CACHE_BUSY_WAIT, cycles);
    end
    rdata = bus.DATA_CACHE_READ_DATA;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(NR, NW, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(LW, NW, 32'h40, 32'h0);
    #1;
    n_checks++; if (bus.DATA_CACHE_BUSY_WAIT !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.DATA_CACHE_BUSY_WAIT); end
    n_checks++; if (bus.DATA_CACHE_READ_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.DATA_CACHE_READ_DATA); end
    n_checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_rw: got %b want 00", {bus.mem_read, bus.mem_write}); end
    n_checks++; if (bus.mem_address !== 28'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_address); end
    n_checks++; if (bus.mem_writedata !== 128'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_writedata); end
    n_checks++; if ({bus.hit_count, bus.miss_count} !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", bus.hit_count, bus.miss_count); end
    drive(NR, NW, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_miss();
    int cyc;
    logic [31:0] rd, ev;
    sb.push_back(32'h11111111);
    run_req(LW, NW, 32'h40, 32'h0, cyc, rd);
    ev = sb.pop_front();
    n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL clean_miss_data: got %h want %h", rd, ev); end
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL clean_miss_cycles: got %0d want 6", cyc); end
    n_checks++; if (last_rd_addr !== 28'h4) begin n_fail++; $display("FAIL clean_miss_fetch_addr: got %h want 4", last_rd_addr); end
    n_checks++; if (rd_cnt !== 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL clean_miss_xfers: got rd=%0d wr=%0d want 1/0", rd_cnt, wr_cnt); end
  endtask

  task automatic test_byte_ops();
    int cyc;
    logic [31:0] rd, ev;
    op_t t[4] = '{
      '{LB,  NW, 32'h43, 32'h0,        32'h00000011, 0},
      '{NR,  SB, 32'h43, 32'hFFFFFF80, 32'h0,        0},
      '{LB,  NW, 32'h43, 32'h0,        32'hFFFFFF80, 0},
      '{LBU, NW, 32'h43, 32'h0,        32'h00000080, 0}
    };
    foreach (t[i]) begin
      if (t[i].re[3]) sb.push_back(t[i].exp);
      run_req(t[i].re, t[i].we, t[i].a, t[i].d, cyc, rd);
      n_checks++; if (cyc !== t[i].cyc) begin n_fail++; $display("FAIL byte_ops[%0d]_cycles: got %0d want %0d", i, cyc, t[i].cyc); end
      if (t[i].re[3]) begin
        ev = sb.pop_front();
        n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL byte_ops[%0d]_data: got %h want %h", i, rd, ev); end
      end
    end
  endtask

  task automatic test_half_ops();
    int cyc;
    logic [31:0] rd, ev;
    op_t t[5] = '{
      '{NR,  SH, 32'h46, 32'h1234ABCD, 32'h0,        0},
      '{LH,  NW, 32'h46, 32'h0,        32'hFFFFABCD, 0},
      '{LHU, NW, 32'h46, 32'h0,        32'h0000ABCD, 0},
      '{LW,  NW, 32'h44, 32'h0,        32'hABCD2222, 0},
      '{LW,  NW, 32'h40, 32'h0,        32'h80111111, 0}
    };
    foreach (t[i]) begin
      if (t[i].re[3]) sb.push_back(t[i].exp);
      run_req(t[i].re, t[i].we, t[i].a, t[i].d, cyc, rd);
      n_checks++; if (cyc !== t[i].cyc) begin n_fail++; $display("FAIL half_ops[%0d]_cycles: got %0d want %0d", i, cyc, t[i].cyc); end
      if (t[i].re[3]) begin
        ev = sb.pop_front();
        n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL half_ops[%0d]_data: got %h want %h", i, rd, ev); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] rd, ev;
    op_t t[4] = '{
      '{NR,  SW, 32'h48, 32'hCAFEF00D, 32'h0,        0},
      '{LW,  NW, 32'h48, 32'h0,        32'hCAFEF00D, 0},
      '{LB,  NW, 32'h4B, 32'h0,        32'hFFFFFFCA, 0},
      '{LHU, NW, 32'h4A, 32'h0,        32'h0000CAFE, 0}
    };
    foreach (t[i]) begin
      if (t[i].re[3]) sb.push_back(t[i].exp);
      run_req(t[i].re, t[i].we, t[i].a, t[i].d, cyc, rd);
      n_checks++; if (cyc !== t[i].cyc) begin n_fail++; $display("FAIL b2b[%0d]_cycles: got %0d want %0d", i, cyc, t[i].cyc); end
      if (t[i].re[3]) begin
        ev = sb.pop_front();
        n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL b2b[%0d]_data: got %h want %h", i, rd, ev); end
      end
    end
  endtask

  task automatic test_dirty_evict();
    int cyc;
    logic [31:0] rd, ev;
    run_req(NR, SW, 32'h40, 32'hDEADBEEF, cyc, rd);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL evict_store_cycles: got %0d want 0", cyc); end
    sb.push_back(32'hCCCC0000);
    run_req(LW, NW, 32'hC0, 32'h0, cyc, rd);
    ev = sb.pop_front();
    n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL evict_data: got %h want %h", rd, ev); end
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL evict_cycles: got %0d want 10", cyc); end
    n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL evict_wr_count: got %0d want 1", wr_cnt); end
    n_checks++; if (last_wr_addr !== 28'h4) begin n_fail++; $display("FAIL evict_wb_addr: got %h want 4", last_wr_addr); end
    n_checks++; if (last_wr_data !== 128'h44444444_CAFEF00D_ABCD2222_DEADBEEF) begin
      n_fail++; $display("FAIL evict_wb_data: got %h want 44444444cafef00dabcd2222deadbeef", last_wr_data); end
    n_checks++; if (last_rd_addr !== 28'hC) begin n_fail++; $display("FAIL evict_fetch_addr: got %h want c", last_rd_addr); end
    sb.push_back(32'h44444444);
    run_req(LW, NW, 32'h4C, 32'h0, cyc, rd);
    ev = sb.pop_front();
    n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL refetch_data: got %h want %h", rd, ev); end
    n_checks++; if (cyc !== 6 || wr_cnt !== 1) begin n_fail++; $display("FAIL refetch_clean: got cyc=%0d wr=%0d want 6/1", cyc, wr_cnt); end
    sb.push_back(32'hDEADBEEF);
    run_req(LW, NW, 32'h40, 32'h0, cyc, rd);
    ev = sb.pop_front();
    n_checks++; if (rd !== ev || cyc !== 0) begin n_fail++; $display("FAIL refetch_hit: got %h/%0d want %h/0", rd, cyc, ev); end
    n_checks++; if (both_hi !== 0) begin n_fail++; $display("FAIL mem_rw_exclusive: got %0d overlaps want 0", both_hi); end
  endtask

  task automatic test_reset_mid_fetch();
    int cyc, rd0;
    logic [31:0] rd, ev;
    drive(LW, NW, 32'h240, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 28'h24) begin
      n_fail++; $display("FAIL mid_fetch_req: got rd=%b addr=%h want 1/24", bus.mem_read, bus.mem_address); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL mid_reset_mem_read: got %b want 0", bus.mem_read); end
    n_checks++; if (bus.DATA_CACHE_BUSY_WAIT !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", bus.DATA_CACHE_BUSY_WAIT); end
    n_checks++; if (bus.mem_address !== 28'h0 || bus.DATA_CACHE_READ_DATA !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got addr=%h rdata=%h want 0/0", bus.mem_address, bus.DATA_CACHE_READ_DATA); end
    drive(NR, NW, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd0 = rd_cnt;
    sb.push_back(32'hDEADBEEF);
    run_req(LW, NW, 32'h40, 32'h0, cyc, rd);
    ev = sb.pop_front();
    n_checks++; if (rd !== ev) begin n_fail++; $display("FAIL post_reset_data: got %h want %h", rd, ev); end
    n_checks++; if (cyc !== 6 || rd_cnt !== rd0 + 1) begin
      n_fail++; $display("FAIL post_reset_miss: got cyc=%0d fetches=%0d want 6/1", cyc, rd_cnt - rd0); end
  endtask

  task automatic test_stats();
    int cyc;
    logic [31:0] rd, ev, exp_hit, exp_miss;
    op_t t[4] = '{
      '{LW, NW, 32'h40,  32'h0, 32'hDEADBEEF, 6},
      '{LW, NW, 32'h44,  32'h0, 32'hABCD2222, 0},
      '{LB, NW, 32'h40,  32'h0, 32'hFFFFFFEF, 0},
      '{LW, NW, 32'h150, 32'h0, 32'h00000000, 6}
    };
    drive(NR, NW, 32'h0, 32'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i].re, t[i].we, t[i].a, t[i].d, cyc, rd);
      ev = sb.pop_front();
      n_checks++; if (rd !== ev || cyc !== t[i].cyc) begin
        n_fail++; $display("FAIL stats_seq[%0d]: got %h/%0d want %h/%0d", i, rd, cyc, ev, t[i].cyc); end
    end
    drive(NR, NW, 32'h0, 32'h0);
    #1;
`ifdef DATA_CACHE_STATS_EN
    exp_hit  = 32'd2;
    exp_miss = 32'd2;
`else
    exp_hit  = 32'd0;
    exp_miss = 32'd0;
`endif
    n_checks++; if (bus.hit_count !== exp_hit) begin n_fail++; $display("FAIL hit_count: got %0d want %0d", bus.hit_count, exp_hit); end
    n_checks++; if (bus.miss_count !== exp_miss) begin n_fail++; $display("FAIL miss_count: got %0d want %0d", bus.miss_count, exp_miss); end
  endtask

  initial begin
    mem_blk[28'h4] = 128'h44444444_33333333_22222222_11111111;
    mem_blk[28'hC] = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    test_reset();
    test_clean_miss();
    test_byte_ops();
    test_half_ops();
    test_back_to_back();
    test_dirty_evict();
    test_reset_mid_fetch();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
